// File: rtl/dac_link_pkg.sv
// dac_link_pkg: shared types, lane widths and word packing order
// for the dual-port DDR DAC link (common to tx and rx sides).
package dac_link_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } link_state_e;

  localparam int LANE_W = 16;
  localparam int WORD_W = 4 * LANE_W;
  localparam int CNT_W  = 8;

  localparam int OFF_A_RISE = 0;
  localparam int OFF_A_FALL = 16;
  localparam int OFF_B_RISE = 32;
  localparam int OFF_B_FALL = 48;

  typedef struct packed {
    logic [LANE_W-1:0] a_rise;
    logic [LANE_W-1:0] a_fall;
    logic [LANE_W-1:0] b_rise;
    logic [LANE_W-1:0] b_fall;
    logic              fa_rise;
    logic              fa_fall;
    logic              fb_rise;
    logic              fb_fall;
    logic              clr;
  } rx_s1_t;

  function automatic logic [WORD_W-1:0] pack_word(
    input logic [LANE_W-1:0] a_rise,
    input logic [LANE_W-1:0] a_fall,
    input logic [LANE_W-1:0] b_rise,
    input logic [LANE_W-1:0] b_fall
  );
    logic [WORD_W-1:0] w;
    w = '0;
    w[OFF_A_RISE +: LANE_W] = a_rise;
    w[OFF_A_FALL +: LANE_W] = a_fall;
    w[OFF_B_RISE +: LANE_W] = b_rise;
    w[OFF_B_FALL +: LANE_W] = b_fall;
    return w;
  endfunction

endpackage

// File: rtl/dac_link_rx_frame_fsm.sv
// dac_link_frame_fsm: frame-pattern lock tracker.
// Lock after LOCK_CNT good cycles, drop after UNLOCK_CNT bad ones.
module dac_link_frame_fsm
  import dac_link_pkg::*;
#(
  parameter int LOCK_CNT   = 16,
  parameter int UNLOCK_CNT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic consistent_i,
  input  logic good_i,
  output logic locked_o,
  output logic lost_set_o,
  output logic err_inc_o
);

  localparam logic [CNT_W-1:0] LOCK_C   = CNT_W'(LOCK_CNT);
  localparam logic [CNT_W-1:0] UNLOCK_C = CNT_W'(UNLOCK_CNT);
  localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

  link_state_e      state_q;
  logic [CNT_W-1:0] good_cnt_q;
  logic [CNT_W-1:0] bad_cnt_q;
  logic             locked_q;
  logic [CNT_W-1:0] good_inc;
  logic [CNT_W-1:0] bad_inc;
  logic             in_lock;

  // Evaluated-cycle strobes for the counter side of the receiver
  always_comb begin
    good_inc   = good_cnt_q + ONE_C;
    bad_inc    = bad_cnt_q + ONE_C;
    in_lock    = (state_q == LOCKED);
    err_inc_o  = in_lock && !good_i;
    lost_set_o = err_inc_o && (bad_inc == UNLOCK_C);
  end

  // Lock state machine with registered locked flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SEARCH;
      good_cnt_q <= '0;
      bad_cnt_q  <= '0;
      locked_q   <= 1'b0;
    end else begin
      unique case (state_q)
        SEARCH: begin
          if (consistent_i) begin
            state_q    <= CHECK;
            good_cnt_q <= ONE_C;
          end
        end
        CHECK: begin
          if (!good_i) begin
            state_q    <= SEARCH;
            good_cnt_q <= '0;
          end else if (good_inc == LOCK_C) begin
            state_q    <= LOCKED;
            good_cnt_q <= '0;
            bad_cnt_q  <= '0;
            locked_q   <= 1'b1;
          end else begin
            good_cnt_q <= good_inc;
          end
        end
        LOCKED: begin
          if (good_i) begin
            bad_cnt_q <= '0;
          end else if (bad_inc == UNLOCK_C) begin
            state_q   <= SEARCH;
            bad_cnt_q <= '0;
            locked_q  <= 1'b0;
          end else begin
            bad_cnt_q <= bad_inc;
          end
        end
        default: begin
          state_q    <= SEARCH;
          good_cnt_q <= '0;
          bad_cnt_q  <= '0;
          locked_q   <= 1'b0;
        end
      endcase
    end
  end

  assign locked_o = locked_q;

endmodule

// File: rtl/dac_link_rx.sv
// dac_link_rx: receive side of the dual-port DDR DAC link.
// Checks the toggling frame, locks, and repacks the 64-bit word.
module dac_link_rx
  import dac_link_pkg::*;
#(
  parameter int LOCK_CNT   = 16,
  parameter int UNLOCK_CNT = 4,
  parameter int ERR_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [LANE_W-1:0] data_a_rise,
  input  logic [LANE_W-1:0] data_a_fall,
  input  logic [LANE_W-1:0] data_b_rise,
  input  logic [LANE_W-1:0] data_b_fall,
  input  logic              frame_a_rise,
  input  logic              frame_a_fall,
  input  logic              frame_b_rise,
  input  logic              frame_b_fall,
  input  logic              err_clear,
  output logic [WORD_W-1:0] data_out,
  output logic              data_valid,
  output logic              data_phase,
  output logic              locked,
  output logic              lock_lost,
  output logic [ERR_W-1:0]  err_count
);

  localparam logic [ERR_W-1:0] ERR_ONE = ERR_W'(1);

  rx_s1_t            s1_d;
  rx_s1_t            s1_q;
  logic              prev_q;
  logic              consistent;
  logic              good;
  logic              lock_w;
  logic              lost_set;
  logic              err_inc;
  logic [WORD_W-1:0] data_d;
  logic [WORD_W-1:0] data_q;
  logic              valid_d;
  logic              valid_q;
  logic              phase_q;
  logic [ERR_W-1:0]  err_d;
  logic [ERR_W-1:0]  err_q;
  logic              lost_d;
  logic              lost_q;

  // Bundle the raw post-IDDR inputs for the first register stage
  always_comb begin
    s1_d.a_rise  = data_a_rise;
    s1_d.a_fall  = data_a_fall;
    s1_d.b_rise  = data_b_rise;
    s1_d.b_fall  = data_b_fall;
    s1_d.fa_rise = frame_a_rise;
    s1_d.fa_fall = frame_a_fall;
    s1_d.fb_rise = frame_b_rise;
    s1_d.fb_fall = frame_b_fall;
    s1_d.clr     = err_clear;
  end

  // Stage 1: input capture and previous-frame history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= '0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      prev_q <= s1_q.fa_rise;
    end
  end

  // Frame checks on the stage-1 sample
  always_comb begin
    consistent = (s1_q.fa_rise == s1_q.fa_fall)
              && (s1_q.fb_rise == s1_q.fb_fall)
              && (s1_q.fa_rise == s1_q.fb_rise);
    good = consistent && (s1_q.fa_rise != prev_q);
  end

  dac_link_frame_fsm #(
    .LOCK_CNT   (LOCK_CNT),
    .UNLOCK_CNT (UNLOCK_CNT)
  ) u_fsm (
    .clk          (clk),
    .rst_n        (rst_n),
    .consistent_i (consistent),
    .good_i       (good),
    .locked_o     (lock_w),
    .lost_set_o   (lost_set),
    .err_inc_o    (err_inc)
  );

  // Next output word, qualifier and health counters
  always_comb begin
    data_d  = pack_word(s1_q.a_rise, s1_q.a_fall,
                        s1_q.b_rise, s1_q.b_fall);
    valid_d = lock_w && good;
    err_d   = err_q;
    lost_d  = lost_q;
    if (s1_q.clr) begin
      err_d  = '0;
      lost_d = 1'b0;
    end else begin
      if (err_inc && (err_q != '1)) begin
        err_d = err_q + ERR_ONE;
      end
      if (lost_set) begin
        lost_d = 1'b1;
      end
    end
  end

  // Stage 2: registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      phase_q <= 1'b0;
      err_q   <= '0;
      lost_q  <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      phase_q <= s1_q.fa_rise;
      err_q   <= err_d;
      lost_q  <= lost_d;
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign data_phase = phase_q;
  assign locked     = lock_w;
  assign lock_lost  = lost_q;
  assign err_count  = err_q;

endmodule

// File: tb/tb_dac_link_rx.sv
// tb_dac_link_rx: directed bench for the DAC link receiver.
// Inputs change on negedge; outputs lag the driven vector by 2 edges.
module tb_dac_link_rx;

  logic        clk;
  logic        rst_n;
  logic [15:0] data_a_rise;
  logic [15:0] data_a_fall;
  logic [15:0] data_b_rise;
  logic [15:0] data_b_fall;
  logic        frame_a_rise;
  logic        frame_a_fall;
  logic        frame_b_rise;
  logic        frame_b_fall;
  logic        err_clear;
  logic [63:0] data_out;
  logic        data_valid;
  logic        data_phase;
  logic        locked;
  logic        lock_lost;
  logic [3:0]  err_count;

  int          n_chk;
  int          n_err;
  logic        fr;
  logic [15:0] dar;
  logic [15:0] daf;
  logic [15:0] dbr;
  logic [15:0] dbf;

  localparam logic [63:0] W_DEF = 64'h4444_3333_2222_1111;
  localparam logic [63:0] W_ALT = 64'h4567_0123_BEEF_DEAD;

  dac_link_rx #(
    .LOCK_CNT   (16),
    .UNLOCK_CNT (4),
    .ERR_W      (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_a_rise  (data_a_rise),
    .data_a_fall  (data_a_fall),
    .data_b_rise  (data_b_rise),
    .data_b_fall  (data_b_fall),
    .frame_a_rise (frame_a_rise),
    .frame_a_fall (frame_a_fall),
    .frame_b_rise (frame_b_rise),
    .frame_b_fall (frame_b_fall),
    .err_clear    (err_clear),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .data_phase   (data_phase),
    .locked       (locked),
    .lock_lost    (lock_lost),
    .err_count    (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input logic ar, input logic af,
                      input logic br, input logic bf,
                      input logic clr);
    @(negedge clk);
    frame_a_rise = ar;
    frame_a_fall = af;
    frame_b_rise = br;
    frame_b_fall = bf;
    data_a_rise  = dar;
    data_a_fall  = daf;
    data_b_rise  = dbr;
    data_b_fall  = dbf;
    err_clear    = clr;
  endtask

  task automatic tg(input logic clr);
    fr = ~fr;
    tick(fr, fr, fr, fr, clr);
  endtask

  task automatic ts(input logic clr);
    tick(fr, fr, fr, fr, clr);
  endtask

  task automatic idle();
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic set_def();
    dar = 16'h1111; daf = 16'h2222;
    dbr = 16'h3333; dbf = 16'h4444;
  endtask

  task automatic set_alt();
    dar = 16'hDEAD; daf = 16'hBEEF;
    dbr = 16'h0123; dbf = 16'h4567;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_data"},  data_out, 64'h0);
    chk({tag, "_valid"}, 64'(data_valid), 64'h0);
    chk({tag, "_phase"}, 64'(data_phase), 64'h0);
    chk({tag, "_lock"},  64'(locked), 64'h0);
    chk({tag, "_lost"},  64'(lock_lost), 64'h0);
    chk({tag, "_err"},   64'(err_count), 64'h0);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    fr    = 1'b1;
    set_def();
    rst_n        = 1'b0;
    frame_a_rise = 1'b1;
    frame_a_fall = 1'b0;
    frame_b_rise = 1'b0;
    frame_b_fall = 1'b0;
    data_a_rise  = '0;
    data_a_fall  = '0;
    data_b_rise  = '0;
    data_b_fall  = '0;
    err_clear    = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("rst");
    rst_n = 1'b1;
    repeat (4) idle();

    // Lock: 16 good evaluated cycles
    fr = 1'b1;
    for (int k = 1; k <= 17; k++) tg(1'b0);
    chk("lock_v15", 64'(locked), 64'h0);
    tg(1'b0);
    chk("lock_v16", 64'(locked), 64'h1);
    chk("lock_v16_valid", 64'(data_valid), 64'h0);
    set_alt();
    tg(1'b0);
    set_def();
    chk("v17_valid", 64'(data_valid), 64'h1);
    chk("v17_data", data_out, W_DEF);
    chk("v17_phase", 64'(data_phase), 64'h0);
    tg(1'b0);
    chk("v18_phase", 64'(data_phase), 64'h1);
    tg(1'b0);
    chk("v19_data", data_out, W_ALT);
    chk("v19_err", 64'(err_count), 64'h0);

    // Three stuck cycles while locked
    ts(1'b0);
    set_alt();
    ts(1'b0);
    set_def();
    ts(1'b0);
    chk("s1_valid", 64'(data_valid), 64'h0);
    chk("s1_lock", 64'(locked), 64'h1);
    tg(1'b0);
    chk("s2_valid", 64'(data_valid), 64'h0);
    chk("s2_data", data_out, W_ALT);
    tg(1'b0);
    chk("s3_valid", 64'(data_valid), 64'h0);
    chk("s3_err", 64'(err_count), 64'h3);
    chk("s3_lock", 64'(locked), 64'h1);
    tg(1'b0);
    chk("g1_valid", 64'(data_valid), 64'h1);
    chk("g1_err", 64'(err_count), 64'h3);

    // Clear on a good cycle, then four stuck cycles unlock
    tg(1'b1);
    ts(1'b0);
    ts(1'b0);
    chk("clr_err", 64'(err_count), 64'h0);
    ts(1'b0);
    chk("u1_err", 64'(err_count), 64'h1);
    ts(1'b0);
    tg(1'b0);
    chk("u3_lock", 64'(locked), 64'h1);
    chk("u3_lost", 64'(lock_lost), 64'h0);
    chk("u3_err", 64'(err_count), 64'h3);
    tg(1'b0);
    chk("u4_lock", 64'(locked), 64'h0);
    chk("u4_lost", 64'(lock_lost), 64'h1);
    chk("u4_err", 64'(err_count), 64'h4);
    for (int k = 3; k <= 17; k++) tg(1'b0);
    chk("rl_v15", 64'(locked), 64'h0);
    tg(1'b0);
    chk("rl_v16", 64'(locked), 64'h1);
    chk("rl_lost", 64'(lock_lost), 64'h1);
    tg(1'b0);
    chk("rl_valid", 64'(data_valid), 64'h1);

    // Saturation: 20 isolated bad cycles on a 4-bit counter
    for (int i = 0; i < 20; i++) begin
      ts(1'b0);
      tg(1'b0);
      if (i == 5) begin
        chk("sat_mid_err", 64'(err_count), 64'h9);
        chk("sat_mid_valid", 64'(data_valid), 64'h1);
      end
    end
    tg(1'b0);
    tg(1'b0);
    chk("sat_err", 64'(err_count), 64'hF);
    chk("sat_lock", 64'(locked), 64'h1);

    // Clear coincident with a bad cycle
    ts(1'b1);
    tg(1'b0);
    tg(1'b0);
    chk("clrbad_err", 64'(err_count), 64'h0);
    chk("clrbad_lost", 64'(lock_lost), 64'h0);
    chk("clrbad_lock", 64'(locked), 64'h1);
    tg(1'b0);
    chk("clrbad_valid", 64'(data_valid), 64'h1);

    // Asynchronous reset between edges while locked
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_zero("arst");
    repeat (3) idle();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) idle();
    chk("arst_lock", 64'(locked), 64'h0);

    // Glitch at good_cnt 10 forces a full restart
    fr = 1'b1;
    for (int k = 1; k <= 9; k++) tg(1'b0);
    fr = ~fr;
    tick(fr, fr, fr, ~fr, 1'b0);
    for (int k = 1; k <= 8; k++) tg(1'b0);
    chk("gl_q6", 64'(locked), 64'h0);
    for (int k = 9; k <= 17; k++) tg(1'b0);
    chk("gl_q15", 64'(locked), 64'h0);
    tg(1'b0);
    chk("gl_q16", 64'(locked), 64'h1);
    chk("gl_err", 64'(err_count), 64'h0);
    chk("gl_lost", 64'(lock_lost), 64'h0);
    tg(1'b0);
    chk("gl_valid", 64'(data_valid), 64'h1);
    chk("gl_data", data_out, W_DEF);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
